// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare, iterative one-bit-per-cycle shifter,
// valid/ready on both the operand side and the result side.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            cf,
  output logic            vf,
  output logic            sf,
  output logic            illegal,
  output logic [1:0]      dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid may not depend on ready, and the initiator holds its payload until the transfer.

  localparam int SW = $clog2(XLEN);

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_OR   = 4'b0100;
  localparam logic [3:0] SEL_AND  = 4'b0101;
  localparam logic [3:0] SEL_BR   = 4'b0110;
  localparam logic [3:0] SEL_XOR  = 4'b0111;
  localparam logic [3:0] SEL_SLL  = 4'b1000;
  localparam logic [3:0] SEL_SRL  = 4'b1001;
  localparam logic [3:0] SEL_SRA  = 4'b1011;
  localparam logic [3:0] SEL_SLT  = 4'b1101;
  localparam logic [3:0] SEL_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [3:0]      sel_q, sel_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zf_q, zf_d, cf_q, cf_d, vf_q, vf_d, sf_q, sf_d, ill_q, ill_d;

  logic [XLEN:0]   diff;
  logic            sub_c, sub_v, sub_s;
  logic [XLEN-1:0] alu_r;
  logic            alu_cmp, alu_ill, is_shift;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] sh_next;

  // One subtractor feeds SUB, BRANCH, SLT and SLTU and their flags.
  always_comb begin
    diff  = {1'b0, op_a} + {1'b0, ~op_b} + {{XLEN{1'b0}}, 1'b1};
    sub_c = diff[XLEN];
    sub_s = diff[XLEN-1];
    sub_v = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
    shamt = op_b[SW-1:0];
    is_shift = (alu_sel == SEL_SLL) || (alu_sel == SEL_SRL) || (alu_sel == SEL_SRA);
    alu_r   = '0;
    alu_cmp = 1'b0;
    alu_ill = 1'b0;
    case (alu_sel)
      SEL_ADD:          alu_r = op_a + op_b;
      SEL_SUB, SEL_BR: begin alu_r = diff[XLEN-1:0]; alu_cmp = 1'b1; end
      SEL_OR:           alu_r = op_a | op_b;
      SEL_AND:          alu_r = op_a & op_b;
      SEL_XOR:          alu_r = op_a ^ op_b;
      SEL_SLL, SEL_SRL, SEL_SRA: alu_r = op_a;
      SEL_SLT:  begin alu_r = {{(XLEN-1){1'b0}}, sub_s ^ sub_v}; alu_cmp = 1'b1; end
      SEL_SLTU: begin alu_r = {{(XLEN-1){1'b0}}, ~sub_c};       alu_cmp = 1'b1; end
      default:          alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (sel_q)
      SEL_SLL: sh_next = {sh_q[XLEN-2:0], 1'b0};
      SEL_SRL: sh_next = {1'b0, sh_q[XLEN-1:1]};
      default: sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    result_d = result_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    vf_d     = vf_q;
    sf_d     = sf_q;
    ill_d    = ill_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sel_d = alu_sel;
          if (is_shift && (shamt != '0)) begin
            sh_d    = op_a;
            cnt_d   = shamt;
            state_d = S_SHIFT;
          end else begin
            result_d = alu_r;
            zf_d     = (alu_r == '0) && !alu_ill;
            cf_d     = alu_cmp & sub_c;
            vf_d     = alu_cmp & sub_v;
            sf_d     = alu_cmp & sub_s;
            ill_d    = alu_ill;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - {{(SW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(SW-1){1'b0}}, 1'b1}) begin
          result_d = sh_next;
          zf_d     = (sh_next == '0);
          cf_d     = 1'b0;
          vf_d     = 1'b0;
          sf_d     = 1'b0;
          ill_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      vf_q     <= 1'b0;
      sf_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      vf_q     <= vf_d;
      sf_q     <= sf_d;
      ill_q    <= ill_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign vf        = vf_q;
  assign sf        = sf_q;
  assign illegal   = ill_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: table of hand-derived vectors, scoreboard queue of expected
// {illegal,zf,cf,vf,sf,result}, plus stall and reset-abort sequences.
module tb_alu_exec_unit;
  localparam int XLEN = 32;
  localparam int W    = XLEN + 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] op_a, op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zf, cf, vf, sf, illegal;
  logic [1:0]      dbg_state;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zf(zf), .cf(cf), .vf(vf), .sf(sf),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            zf, cf, vf, sf, ill;
    int              lat;
    int              stall;
  } vec_t;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [3:0] sel, input logic [XLEN-1:0] a, b, res,
                              input logic z, c, v, s, il, input int lat, input int stall);
    vec_t t;
    t.sel = sel; t.a = a; t.b = b; t.res = res;
    t.zf = z; t.cf = c; t.vf = v; t.sf = s; t.ill = il;
    t.lat = lat; t.stall = stall;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int guard;
    int lat;
    int low_cnt;
    logic [W-1:0] e;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    alu_sel  = v.sel;
    op_a     = v.a;
    op_b     = v.b;
    in_valid = 1'b1;
    exp_q.push_back({v.ill, v.zf, v.cf, v.vf, v.sf, v.res});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    alu_sel  = 4'($urandom_range(0, 15));
    op_a     = $urandom;
    op_b     = $urandom;
    lat = 1;
    low_cnt = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) low_cnt++;
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(v.lat));
    e = exp_q.pop_front();
    chk("outputs", {27'd0, illegal, zf, cf, vf, sf, result}, {27'd0, e});
    for (int i = 0; i < v.stall; i++) begin
      if (!in_ready) low_cnt++;
      in_valid = 1'b1;
      alu_sel  = 4'b0000;
      @(negedge clk);
      chk("stall_hold", {30'd0, out_valid, in_ready, result}, {30'd0, 1'b1, 1'b0, e[XLEN-1:0]});
    end
    if (!in_ready) low_cnt++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_low_cycles", 64'(low_cnt), 64'(v.lat + v.stall));
    chk("release", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  vec_t tbl[16];
  vec_t t;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_sel = '0; op_a = '0; op_b = '0;
    //                sel      a             b             result        zf cf vf sf il lat st
    tbl[0]  = mk(4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 0, 0, 1, 0);
    tbl[2]  = mk(4'b1101, 32'h80000000, 32'h00000001, 32'h00000001, 0, 1, 1, 0, 0, 1, 0);
    tbl[3]  = mk(4'b1111, 32'h80000000, 32'h00000001, 32'h00000000, 1, 1, 1, 0, 0, 1, 0);
    tbl[4]  = mk(4'b1011, 32'hF0000000, 32'h00000004, 32'hFF000000, 0, 0, 0, 0, 0, 5, 0);
    tbl[5]  = mk(4'b1000, 32'h12345678, 32'h00000000, 32'h12345678, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(4'b0111, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 0, 0, 0, 0, 0, 1, 10);
    tbl[7]  = mk(4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0, 1, 0, 1, 0);
    tbl[8]  = mk(4'b0100, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 0, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(4'b0101, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(4'b1001, 32'h80000000, 32'h0000001F, 32'h00000001, 0, 0, 0, 0, 0, 32, 0);
    tbl[11] = mk(4'b1000, 32'h00000001, 32'h0000001F, 32'h80000000, 0, 0, 0, 0, 0, 32, 0);
    tbl[12] = mk(4'b1011, 32'h40000000, 32'h00000021, 32'h20000000, 0, 0, 0, 0, 0, 2, 2);
    tbl[13] = mk(4'b1001, 32'h00000001, 32'h00000001, 32'h00000000, 1, 0, 0, 0, 0, 2, 0);
    tbl[14] = mk(4'b1101, 32'h00000001, 32'h80000000, 32'h00000000, 1, 0, 1, 1, 0, 1, 0);
    tbl[15] = mk(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {25'd0, dbg_state, in_ready, out_valid, illegal, zf, cf, vf, sf, result},
        {25'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});

    for (int i = 0; i < 16; i++) run_op(tbl[i]);

    // Abandon a long shift with a reset partway through.
    alu_sel = 4'b1000; op_a = 32'h00000001; op_b = 32'h0000001F; in_valid = 1'b1;
    exp_q.push_back({5'b00000, 32'h80000000});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_shift_busy", {62'd0, out_valid, in_ready}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    chk("abort_reset", {30'd0, out_valid, in_ready, result}, {30'd0, 1'b0, 1'b1, 32'd0});
    @(negedge clk);
    chk("abort_stays_idle", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});

    t = mk(4'b0010, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 0, 0, 0, 1, 1, 0);
    run_op(t);
    t = mk(4'b0000, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0, 0, 0, 0, 1, 0);
    run_op(t);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
